// File: rtl/shift_pkg.sv
// Shared types for the shift arbiter slice; SHIFT_ARB_ROTATE_EN adds the EXEC2 rotate pass.
// Combinational definitions only: no latency, no backpressure.
package shift_pkg;
  localparam int SHIFT_W = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
`ifdef SHIFT_ARB_ROTATE_EN
    , EXEC2
`endif
  } state_t;

  typedef struct packed {
    logic [SHIFT_W-1:0] data;
    logic [SHAMT_W-1:0] shamt;
    logic               left;
    logic               arith;
    logic               rotate;
  } shift_op_t;
endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between requesters and the shift arbiter; SHIFT_ARB_ROTATE_EN adds req_rotate.
// Valid/ready on both channels; master = requester/consumer side, slave = arbiter.
interface shift_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import shift_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [SHIFT_W*NUM_REQ-1:0] req_data;
  logic [SHAMT_W*NUM_REQ-1:0] req_shamt;
  logic [NUM_REQ-1:0]         req_left;
  logic [NUM_REQ-1:0]         req_arith;
`ifdef SHIFT_ARB_ROTATE_EN
  logic [NUM_REQ-1:0]         req_rotate;
`endif
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_W-1:0]            rsp_id;
  logic [SHIFT_W-1:0]         rsp_data;

  modport master (
`ifdef SHIFT_ARB_ROTATE_EN
    output req_rotate,
`endif
    output req_valid, req_data, req_shamt, req_left, req_arith, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
`ifdef SHIFT_ARB_ROTATE_EN
    input  req_rotate,
`endif
    input  req_valid, req_data, req_shamt, req_left, req_arith, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/barrelShifter.sv
// 32-bit combinational barrel shifter: left logical, right logical or arithmetic.
// Zero latency, no flow control.
module barrelShifter (
  input  logic [31:0] data,
  input  logic [4:0]  shamt,
  input  logic        left,
  input  logic        arith,
  output logic [31:0] result
);
  always_comb begin
    if (left)       result = data << shamt;
    else if (arith) result = $unsigned($signed(data) >>> shamt);
    else            result = data >> shamt;
  end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set req bit scanning from ptr upward with wrap; one-hot grant plus index.
// Purely combinational, no backpressure of its own.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);
  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end
endmodule

// File: rtl/shift_arbiter.sv
// Round-robin share of one barrel shifter, one op in flight; result at T+2 (rotate T+3 with SHIFT_ARB_ROTATE_EN).
// Backpressure: req_ready only in IDLE; a stalled rsp_ready holds the result and blocks new grants.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_arbiter_if.slave bus
);
  state_t             state;
  shift_op_t          op;
  shift_op_t          cand [NUM_REQ];
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [SHIFT_W-1:0] sh_out;
  logic [SHAMT_W-1:0] sh_amt;
  logic               sh_left;
  logic               sh_arith;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cand
    assign cand[g] = '{
      data:   bus.req_data[g*SHIFT_W +: SHIFT_W],
      shamt:  bus.req_shamt[g*SHAMT_W +: SHAMT_W],
      left:   bus.req_left[g],
      arith:  bus.req_arith[g],
`ifdef SHIFT_ARB_ROTATE_EN
      rotate: bus.req_rotate[g]
`else
      rotate: 1'b0
`endif
    };
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req  (bus.req_valid),
    .ptr  (rr_ptr),
    .grant(gnt),
    .idx  (gnt_idx)
  );

  // Gated by rst_n so no grant is offered while reset is held.
  assign bus.req_ready = (state == IDLE && rst_n) ? gnt : '0;

  always_comb begin
    sh_amt   = op.shamt;
    sh_left  = op.left;
    sh_arith = op.arith & ~op.rotate;
`ifdef SHIFT_ARB_ROTATE_EN
    // Second rotate pass: opposite direction by (32 - s) mod 32, logical.
    if (state == EXEC2) begin
      sh_amt   = SHAMT_W'(0) - op.shamt;
      sh_left  = ~op.left;
      sh_arith = 1'b0;
    end
`endif
  end

  barrelShifter u_shift (
    .data  (op.data),
    .shamt (sh_amt),
    .left  (sh_left),
    .arith (sh_arith),
    .result(sh_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op            <= '0;
      rr_ptr        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            op         <= cand[gnt_idx];
            bus.rsp_id <= gnt_idx;
            rr_ptr     <= ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
            state      <= EXEC;
          end
        end
        EXEC: begin
          bus.rsp_data <= sh_out;
`ifdef SHIFT_ARB_ROTATE_EN
          if (op.rotate && op.shamt != '0) begin
            state <= EXEC2;
          end else begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
          end
`else
          state         <= RESP;
          bus.rsp_valid <= 1'b1;
`endif
        end
`ifdef SHIFT_ARB_ROTATE_EN
        EXEC2: begin
          bus.rsp_data  <= bus.rsp_data | sh_out;
          state         <= RESP;
          bus.rsp_valid <= 1'b1;
        end
`endif
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized self-checking bench for shift_arbiter against a spec-level model of arbitration and shifting.
// Build with SHIFT_ARB_ROTATE_EN to also exercise rotates.
module tb_shift_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   m_ptr = 0;

  logic [31:0] t_data [N];
  logic [4:0]  t_sh   [N];
  logic        t_left [N];
  logic        t_arith[N];
  logic        t_rot  [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus();
  shift_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic l, input logic a, input logic r);
    logic [63:0] dd;
    logic [31:0] q;
    if (r) begin
      dd = l ? ({d, d} << s) : ({d, d} >> s);
      return l ? dd[63:32] : dd[31:0];
    end
    if (l) return 32'(64'(d) * (64'd1 << s));
    q = d / (32'd1 << s);
    if (a && d[31]) q = q | ~(32'hFFFF_FFFF / (32'd1 << s));
    return q;
  endfunction

  function automatic int ref_winner(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) if (mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    if ($countones(v) > 1) return -2;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  function automatic int exp_lat(input int w);
    return (t_rot[w] && t_sh[w] != 0) ? 3 : 2;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_ops();
    for (int i = 0; i < N; i++) begin
      bus.req_data[i*32 +: 32] = t_data[i];
      bus.req_shamt[i*5 +: 5]  = t_sh[i];
      bus.req_left[i]          = t_left[i];
      bus.req_arith[i]         = t_arith[i];
`ifdef SHIFT_ARB_ROTATE_EN
      bus.req_rotate[i]        = t_rot[i];
`endif
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      t_data[i]  = $urandom;
      t_sh[i]    = 5'($urandom_range(0, 31));
      t_left[i]  = 1'($urandom);
      t_arith[i] = 1'($urandom);
`ifdef SHIFT_ARB_ROTATE_EN
      t_rot[i]   = 1'($urandom);
`else
      t_rot[i]   = 1'b0;
`endif
    end
  endtask

  task automatic set_op(input int w, input logic [31:0] d, input logic [4:0] s,
                        input logic l, input logic a, input logic r);
    t_data[w] = d; t_sh[w] = s; t_left[w] = l; t_arith[w] = a; t_rot[w] = r;
  endtask

  // Requester `who` alone asserts valid; returns grant seen, result, id and latency in cycles.
  task automatic serve(input int who, output int got, output logic [31:0] res,
                       output int id, output int lat);
    int n;
    apply_ops();
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    bus.req_valid[who] = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 10) begin tick(); n++; end
    got = oh_idx(bus.req_ready);
    tick();
    bus.req_valid = '0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin tick(); lat++; end
    res = bus.rsp_data;
    id  = int'(bus.rsp_id);
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) set_op(i, 32'hFFFF_0000 + i, 5'(i), 1'b0, 1'b0, 1'b0);
    apply_ops();
    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    tick(); tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", bus.rsp_id); end
    checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", bus.rsp_data); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready); end
    rst_n = 1'b1;
    m_ptr = 0;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", bus.req_ready); end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL idle_no_valid got %b exp 0000", bus.req_ready); end
    tick();
  endtask

  task automatic test_round_robin();
    int exp_q[$];
    int gcyc_q[$];
    int grants, rsps, g, e, prev, w, gc;
    for (int i = 0; i < N; i++) set_op(i, 32'h8000_00F0 ^ (i << 8), 5'(i + 1), 1'(i & 1), 1'b1, 1'b0);
    apply_ops();
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    grants = 0; rsps = 0; prev = -1;
    #1;
    for (int t = 0; t < 40 && rsps < 5; t++) begin
      if (bus.rsp_valid) begin
        w  = exp_q.pop_front();
        gc = gcyc_q.pop_front();
        checks++; if (int'(bus.rsp_id) !== w) begin errors++; $display("FAIL rr_rsp_id got %0d exp %0d", bus.rsp_id, w); end
        checks++; if (bus.rsp_data !== ref_shift(t_data[w], t_sh[w], t_left[w], t_arith[w], t_rot[w])) begin
          errors++; $display("FAIL rr_rsp_data got %h exp %h", bus.rsp_data, ref_shift(t_data[w], t_sh[w], t_left[w], t_arith[w], t_rot[w])); end
        checks++; if (cyc - gc !== 2) begin errors++; $display("FAIL rr_latency got %0d exp 2", cyc - gc); end
        rsps++;
      end
      if (bus.req_ready != '0 && grants < 5) begin
        g = oh_idx(bus.req_ready);
        e = ref_winner(4'b1111);
        checks++; if (g !== e) begin errors++; $display("FAIL rr_order got %0d exp %0d", g, e); end
        if (prev >= 0) begin
          checks++; if (cyc - prev !== 3) begin errors++; $display("FAIL rr_interval got %0d exp 3", cyc - prev); end
        end
        prev = cyc;
        m_ptr = (e + 1) % N;
        exp_q.push_back(e);
        gcyc_q.push_back(cyc);
        grants++;
      end
      tick();
      if (grants >= 5) bus.req_valid = '0;
    end
    checks++; if (rsps !== 5) begin errors++; $display("FAIL rr_rsp_count got %0d exp 5", rsps); end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_arith_right();
    int got, id, lat;
    logic [31:0] res;
    set_op(0, 32'h8000_0010, 5'd4, 1'b0, 1'b1, 1'b0);
    serve(0, got, res, id, lat);
    checks++; if (got !== ref_winner(4'b0001)) begin errors++; $display("FAIL sra_grant got %0d exp 0", got); end
    m_ptr = 1;
    checks++; if (res !== 32'hF800_0001) begin errors++; $display("FAIL sra_data got %h exp f8000001", res); end
    checks++; if (id !== 0) begin errors++; $display("FAIL sra_id got %0d exp 0", id); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL sra_latency got %0d exp 2", lat); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL sra_rsp_drop got %b exp 0", bus.rsp_valid); end
    set_op(0, 32'h8000_0010, 5'd4, 1'b0, 1'b0, 1'b0);
    serve(0, got, res, id, lat);
    checks++; if (res !== 32'h0800_0001) begin errors++; $display("FAIL srl_data got %h exp 08000001", res); end
  endtask

  task automatic test_wrap();
    int got, id, lat, g, e, grants;
    logic [31:0] res;
    logic [N-1:0] mask;
    rand_ops();
    for (int i = 0; i < N; i++) t_rot[i] = 1'b0;
    serve(1, got, res, id, lat);
    m_ptr = 2;
    apply_ops();
    mask = 4'b1010;
    bus.req_valid = mask;
    grants = 0;
    #1;
    for (int t = 0; t < 30 && grants < 2; t++) begin
      if (bus.req_ready != '0) begin
        g = oh_idx(bus.req_ready);
        e = ref_winner(mask);
        checks++; if (g !== e) begin errors++; $display("FAIL wrap_order got %0d exp %0d", g, e); end
        mask[e] = 1'b0;
        m_ptr = (e + 1) % N;
        grants++;
      end
      tick();
      bus.req_valid = mask;
    end
    checks++; if (grants !== 2) begin errors++; $display("FAIL wrap_grants got %0d exp 2", grants); end
    bus.req_valid = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_backpressure();
    int n, e;
    logic [31:0] exp_d;
    set_op(0, 32'hC001_D00D, 5'd7, 1'b0, 1'b1, 1'b0);
    apply_ops();
    exp_d = ref_shift(t_data[0], t_sh[0], t_left[0], t_arith[0], t_rot[0]);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 10) begin tick(); n++; end
    m_ptr = 1;
    tick();
    bus.req_valid = '0;
    n = 0;
    while (!bus.rsp_valid && n < 10) begin tick(); n++; end
    for (int k = 0; k < 5; k++) begin
      tick();
      bus.req_valid = N'($urandom);
      rand_ops();
      apply_ops();
      #1;
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b exp 1", bus.rsp_valid); end
      checks++; if (bus.rsp_data !== exp_d) begin errors++; $display("FAIL hold_data got %h exp %h", bus.rsp_data, exp_d); end
      checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL hold_id got %0d exp 0", bus.rsp_id); end
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL hold_no_grant got %b exp 0000", bus.req_ready); end
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL release_valid got %b exp 0", bus.rsp_valid); end
    bus.req_valid = '1;
    #1;
    e = ref_winner(4'b1111);
    checks++; if (oh_idx(bus.req_ready) !== e) begin errors++; $display("FAIL release_grant got %b exp idx %0d", bus.req_ready, e); end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_left();
    int got, id, lat;
    logic [31:0] res;
    set_op(2, 32'h0000_0001, 5'd31, 1'b1, 1'b1, 1'b0);
    serve(2, got, res, id, lat);
    m_ptr = 3;
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL sll31_data got %h exp 80000000", res); end
    checks++; if (id !== 2) begin errors++; $display("FAIL sll31_id got %0d exp 2", id); end
    set_op(2, 32'h0000_0001, 5'd0, 1'b1, 1'b1, 1'b0);
    serve(2, got, res, id, lat);
    checks++; if (res !== 32'h0000_0001) begin errors++; $display("FAIL sll0_data got %h exp 00000001", res); end
  endtask

  task automatic test_random();
    int n, g, e, lat, hold;
    logic [N-1:0] mask;
    logic [31:0] exp_d;
    for (int r = 0; r < 40; r++) begin
      rand_ops();
      apply_ops();
      mask = N'($urandom_range(1, (1 << N) - 1));
      bus.req_valid = mask;
      bus.rsp_ready = 1'b0;
      #1;
      n = 0;
      while (bus.req_ready == '0 && n < 10) begin tick(); n++; end
      g = oh_idx(bus.req_ready);
      e = ref_winner(mask);
      checks++; if (g !== e) begin errors++; $display("FAIL rand_grant got %0d exp %0d mask %b", g, e, mask); end
      m_ptr = (e + 1) % N;
      exp_d = ref_shift(t_data[e], t_sh[e], t_left[e], t_arith[e], t_rot[e]);
      tick();
      bus.req_valid = '0;
      lat = 1;
      while (!bus.rsp_valid && lat < 10) begin tick(); lat++; end
      checks++; if (lat !== exp_lat(e)) begin errors++; $display("FAIL rand_latency got %0d exp %0d", lat, exp_lat(e)); end
      checks++; if (bus.rsp_data !== exp_d) begin errors++; $display("FAIL rand_data got %h exp %h", bus.rsp_data, exp_d); end
      checks++; if (int'(bus.rsp_id) !== e) begin errors++; $display("FAIL rand_id got %0d exp %0d", bus.rsp_id, e); end
      hold = $urandom_range(0, 2);
      for (int k = 0; k < hold; k++) tick();
      bus.rsp_ready = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int n;
    set_op(1, 32'h1234_5678, 5'd3, 1'b0, 1'b0, 1'b0);
    apply_ops();
    bus.req_valid = '0;
    bus.req_valid[1] = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 10) begin tick(); n++; end
    tick();
    bus.req_valid = 4'b0100;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL midrst_id got %0d exp 0", bus.rsp_id); end
    checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL midrst_data got %h exp 0", bus.rsp_data); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready got %b exp 0000", bus.req_ready); end
    bus.req_valid = '0;
    tick(); tick();
    rst_n = 1'b1;
    m_ptr = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp got %b exp 0", bus.rsp_valid); end
    end
  endtask

`ifdef SHIFT_ARB_ROTATE_EN
  task automatic test_rotate();
    int got, id, lat;
    logic [31:0] res;
    set_op(3, 32'h1234_5678, 5'd8, 1'b0, 1'b1, 1'b1);
    serve(3, got, res, id, lat);
    m_ptr = 0;
    checks++; if (res !== 32'h7812_3456) begin errors++; $display("FAIL rotr8_data got %h exp 78123456", res); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL rotr8_latency got %0d exp 3", lat); end
    set_op(3, 32'h1234_5678, 5'd0, 1'b1, 1'b0, 1'b1);
    serve(3, got, res, id, lat);
    checks++; if (res !== 32'h1234_5678 || lat !== 2) begin errors++; $display("FAIL rot0 got %h lat %0d exp 12345678 lat 2", res, lat); end
  endtask
`endif

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    bus.req_data  = '0;
    bus.req_shamt = '0;
    bus.req_left  = '0;
    bus.req_arith = '0;
`ifdef SHIFT_ARB_ROTATE_EN
    bus.req_rotate = '0;
`endif
    test_reset();
    test_round_robin();
    test_arith_right();
    test_wrap();
    test_backpressure();
    test_left();
    test_random();
`ifdef SHIFT_ARB_ROTATE_EN
    test_rotate();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
